// File: rtl/coms_pkg.sv
// Shared types and constants for the motor-board link scheduler.
package coms_pkg;

  typedef enum logic [1:0] {
    NONE            = 2'd0,
    SETPOINT_STATUS = 2'd1,
    CONFIG          = 2'd2
  } cmd_type_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    NEXT     = 2'd3
  } sched_state_t;

  localparam int DEFAULT_RESPONSE_TIMEOUT = 50_000;

  function automatic cmd_type_t select_cmd(input logic pending);
    return pending ? CONFIG : SETPOINT_STATUS;
  endfunction

endpackage

// File: rtl/period_divider.sv
// Sequential restoring divider: one load cycle, 32 shift/subtract steps,
// done pulses with the quotient (never below 1) on the final step.
module period_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] q;
  logic [31:0] d;
  logic [31:0] r;
  logic [4:0]  iter;
  logic [32:0] r_shift;
  logic [32:0] r_sub;
  logic        q_bit;
  logic [31:0] q_next;
  logic [31:0] r_next;

  always_comb begin
    r_shift = {r, q[31]};
    r_sub   = r_shift - {1'b0, d};
    q_bit   = ~r_sub[32];
    q_next  = {q[30:0], q_bit};
    r_next  = q_bit ? r_sub[31:0] : r_shift[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= 32'd1;
      q        <= '0;
      d        <= '0;
      r        <= '0;
      iter     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        q    <= dividend;
        d    <= divisor;
        r    <= '0;
        iter <= '0;
      end else if (busy) begin
        q    <= q_next;
        r    <= r_next;
        iter <= iter + 5'd1;
        if (iter == 5'd31) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= (q_next == '0) ? 32'd1 : q_next;
        end
      end
    end
  end

endmodule

// File: rtl/coms_poll_scheduler.sv
// Sweeps every motor once per update period, issuing a CONFIG or
// SETPOINT_STATUS command to the frame engine and tracking link health.
module coms_poll_scheduler
  import coms_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS        = 6,
  parameter int CLOCK_FREQ_HZ           = 50_000_000,
  parameter int RESPONSE_TIMEOUT_CYCLES = DEFAULT_RESPONSE_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS-1:0] config_dirty,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [1:0]                  cmd_type,
  output logic [7:0]                  cmd_motor,
  input  logic                        rsp_valid,
  input  logic                        rsp_ok,
  output logic [NUMBER_OF_MOTORS-1:0] link_ok,
  output logic [NUMBER_OF_MOTORS-1:0] config_pending,
  output logic                        sweep_done,
  output logic [15:0]                 overrun_count
);

  localparam int IDX_W = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUMBER_OF_MOTORS - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(RESPONSE_TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      CLK_HZ       = 32'(CLOCK_FREQ_HZ);

  sched_state_t          state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic                  cur_cfg;
  logic [31:0]           to_cnt;
  logic [31:0]           freq_q;
  logic [31:0]           period_q;
  logic                  period_valid;
  logic [31:0]           cnt;
  logic                  tick;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [31:0]           div_quotient;
  logic [NUMBER_OF_MOTORS-1:0] pend_clr;

  // Any difference from the latched rate restarts the divider.
  assign div_start = (update_frequency_Hz != freq_q);
  assign idx_next  = idx + 1'b1;

  period_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (CLK_HZ),
    .divisor  (update_frequency_Hz),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_q       <= '0;
      period_q     <= 32'd1;
      period_valid <= 1'b0;
      cnt          <= '0;
      tick         <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (div_start) begin
        freq_q       <= update_frequency_Hz;
        period_valid <= 1'b0;
        cnt          <= '0;
      end else if (div_done) begin
        period_q     <= div_quotient;
        period_valid <= 1'b1;
        cnt          <= '0;
      end else if (div_busy || !period_valid || freq_q == '0) begin
        cnt <= '0;
      end else if (cnt == period_q - 32'd1) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // A successful CONFIG response retires that motor's pending write.
  always_comb begin
    pend_clr = '0;
    if (state == WAIT_RSP && rsp_valid && rsp_ok && cur_cfg)
      pend_clr[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) config_pending <= '1;
    else       config_pending <= (config_pending & ~pend_clr) | config_dirty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      cur_cfg       <= 1'b0;
      to_cnt        <= '0;
      cmd_valid     <= 1'b0;
      cmd_type      <= NONE;
      cmd_motor     <= '0;
      link_ok       <= '0;
      sweep_done    <= 1'b0;
      overrun_count <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (tick && state != IDLE && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
      case (state)
        IDLE: begin
          if (tick) begin
            idx       <= '0;
            cmd_motor <= 8'd0;
            cmd_valid <= 1'b1;
            cmd_type  <= select_cmd(config_pending[0]);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cur_cfg   <= (cmd_type == CONFIG);
            cmd_type  <= NONE;
            to_cnt    <= '0;
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            link_ok[idx] <= rsp_ok;
            state        <= NEXT;
          end else if (to_cnt == TIMEOUT_LAST) begin
            link_ok[idx] <= 1'b0;
            state        <= NEXT;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            sweep_done <= 1'b1;
            state      <= IDLE;
          end else begin
            idx       <= idx_next;
            cmd_motor <= 8'(idx_next);
            cmd_valid <= 1'b1;
            cmd_type  <= select_cmd(config_pending[idx_next]);
            state     <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coms_poll_scheduler.sv
// Directed bench: scaled clock (2 kHz nominal) and 64-cycle timeout keep the run short.
module tb_coms_poll_scheduler;

  localparam logic [1:0] T_SP  = 2'd1;
  localparam logic [1:0] T_CFG = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] update_frequency_Hz;
  logic [5:0]  config_dirty;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [7:0]  cmd_motor;
  logic        rsp_valid;
  logic        rsp_ok;
  logic [5:0]  link_ok;
  logic [5:0]  config_pending;
  logic        sweep_done;
  logic [15:0] overrun_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] hs_motor [64];
  logic [1:0] hs_type  [64];
  int         hs_cyc   [64];
  int         hs_n      = 0;
  int         sweep_cnt = 0;
  int         valid_cnt = 0;
  int         rsp_delay;
  logic [7:0] silent_motor;

  coms_poll_scheduler #(
    .NUMBER_OF_MOTORS        (6),
    .CLOCK_FREQ_HZ           (2000),
    .RESPONSE_TIMEOUT_CYCLES (64)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .update_frequency_Hz (update_frequency_Hz),
    .config_dirty        (config_dirty),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_type            (cmd_type),
    .cmd_motor           (cmd_motor),
    .rsp_valid           (rsp_valid),
    .rsp_ok              (rsp_ok),
    .link_ok             (link_ok),
    .config_pending      (config_pending),
    .sweep_done          (sweep_done),
    .overrun_count       (overrun_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame engine model: logs handshakes and answers after rsp_delay cycles.
  initial begin
    int pend;
    pend      = 0;
    rsp_valid = 1'b0;
    rsp_ok    = 1'b1;
    forever begin
      @(negedge clk);
      #3;
      rsp_valid = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (sweep_done) sweep_cnt++;
        if (cmd_valid) valid_cnt++;
        if (pend > 0) begin
          pend--;
          if (pend == 0) rsp_valid = 1'b1;
        end
        if (cmd_valid && cmd_ready) begin
          if (hs_n < 64) begin
            hs_motor[hs_n] = cmd_motor;
            hs_type[hs_n]  = cmd_type;
            hs_cyc[hs_n]   = cyc;
          end
          hs_n++;
          if (cmd_motor != silent_motor) pend = rsp_delay;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (hs_n < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(hs_n >= n), 32'd1);
  endtask

  task automatic wait_sweeps(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (sweep_cnt < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(sweep_cnt >= n), 32'd1);
  endtask

  initial begin
    int rel;
    int c;
    int c0;
    int n0;
    int v0;
    int k;
    logic [15:0] ov0;

    reset               = 1'b1;
    update_frequency_Hz = 32'd10;
    config_dirty        = '0;
    cmd_ready           = 1'b1;
    rsp_delay           = 10;
    silent_motor        = 8'hFF;

    step(3);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_type", 32'(cmd_type), 32'd0);
    check("rst_cmd_motor", 32'(cmd_motor), 32'd0);
    check("rst_link_ok", 32'(link_ok), 32'h00);
    check("rst_pending", 32'(config_pending), 32'h3F);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_overrun", 32'(overrun_count), 32'd0);

    // Sweep 1: every motor gets its initial CONFIG.
    reset = 1'b0;
    rel   = cyc;
    wait_hs(6, 600, "sweep1_wait");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s1_motor%0d", i), 32'(hs_motor[i]), 32'(i));
      check($sformatf("s1_type%0d", i), 32'(hs_type[i]), 32'(T_CFG));
    end
    check("first_hs_latency", 32'(hs_cyc[0] - rel), 32'd235);
    wait_sweeps(1, 200, "sweep1_done_wait");
    step(1);
    check("s1_pending", 32'(config_pending), 32'h00);
    check("s1_link_ok", 32'(link_ok), 32'h3F);

    // Sweep 2: setpoints, config pulse for motor 3 after its command went out.
    wait_hs(7, 400, "sweep2_wait");
    check("s1_sweep_cnt", 32'(sweep_cnt), 32'd1);
    check("sweep_period", 32'(hs_cyc[6] - hs_cyc[0]), 32'd200);
    wait_hs(10, 100, "s2_m3_wait");
    config_dirty = 6'h08;
    step(1);
    config_dirty = 6'h00;
    step(1);
    check("s2_pending_set", 32'(config_pending), 32'h08);
    wait_hs(12, 200, "s2_end_wait");
    for (int i = 6; i < 12; i++) begin
      check($sformatf("s2_motor%0d", i - 6), 32'(hs_motor[i]), 32'(i - 6));
      check($sformatf("s2_type%0d", i - 6), 32'(hs_type[i]), 32'(T_SP));
    end
    wait_sweeps(2, 200, "sweep2_done_wait");
    step(1);
    check("s2_pending_kept", 32'(config_pending), 32'h08);

    // Sweep 3: motor 3 alone gets CONFIG.
    wait_hs(18, 400, "sweep3_wait");
    for (int i = 12; i < 18; i++)
      check($sformatf("s3_type%0d", i - 12), 32'(hs_type[i]), (i == 15) ? 32'(T_CFG) : 32'(T_SP));
    wait_sweeps(3, 200, "sweep3_done_wait");
    step(1);
    check("s3_pending", 32'(config_pending), 32'h00);

    // Sweep 4: motor 2 has a pending CONFIG and never answers.
    config_dirty = 6'h04;
    step(1);
    config_dirty = 6'h00;
    silent_motor = 8'd2;
    wait_hs(21, 400, "s4_m2_wait");
    c = hs_cyc[20];
    check("s4_m2_motor", 32'(hs_motor[20]), 32'd2);
    check("s4_m2_type", 32'(hs_type[20]), 32'(T_CFG));
    k = 0;
    while (cyc < c + 64 && k < 200) begin
      step(1);
      k++;
    end
    check("to_link_before", 32'(link_ok[2]), 32'd1);
    step(1);
    check("to_link_after", 32'(link_ok[2]), 32'd0);
    wait_hs(22, 100, "s4_m3_wait");
    check("to_next_motor", 32'(hs_motor[21]), 32'd3);
    check("to_next_cycle", 32'(hs_cyc[21] - c), 32'd66);
    wait_sweeps(4, 300, "sweep4_done_wait");
    step(1);
    check("s4_pending", 32'(config_pending), 32'h04);
    check("s4_link_ok", 32'(link_ok), 32'h3B);

    // Sweep 5: motor 2 CONFIG retried and retired.
    silent_motor = 8'hFF;
    wait_hs(30, 400, "sweep5_wait");
    check("s5_m2_motor", 32'(hs_motor[26]), 32'd2);
    check("s5_m2_type", 32'(hs_type[26]), 32'(T_CFG));
    check("s5_m3_type", 32'(hs_type[27]), 32'(T_SP));
    wait_sweeps(5, 200, "sweep5_done_wait");
    step(1);
    check("s5_pending", 32'(config_pending), 32'h00);
    check("s5_link_ok", 32'(link_ok), 32'h3F);
    check("s5_overrun", 32'(overrun_count), 32'd0);

    // Halt: frequency 0 produces no commands.
    update_frequency_Hz = 32'd0;
    n0 = hs_n;
    v0 = valid_cnt;
    step(2000);
    check("halt_no_hs", 32'(hs_n), 32'(n0));
    check("halt_no_valid", 32'(valid_cnt), 32'(v0));

    // Clamp: huge frequency gives period 1; slow responses force overruns.
    update_frequency_Hz = 32'hFFFF_FFFF;
    rsp_delay = 100;
    c0 = cyc;
    wait_hs(n0 + 1, 100, "clamp_wait");
    check("clamp_latency", 32'(hs_cyc[n0] - c0), 32'd36);
    step(5);
    ov0 = overrun_count;
    step(20);
    check("overrun_rate", 32'(overrun_count), 32'(ov0 + 16'd20));

    // Backpressure: command held stable while cmd_ready is low.
    cmd_ready = 1'b0;
    k = 0;
    while (cmd_valid !== 1'b1 && k < 200) begin
      step(1);
      k++;
    end
    check("bp_valid", 32'(cmd_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("bp_hold_valid", 32'(cmd_valid), 32'd1);
      check("bp_hold_motor", 32'(cmd_motor), 32'd1);
      check("bp_hold_type", 32'(cmd_type), 32'(T_SP));
    end
    n0 = hs_n;
    cmd_ready = 1'b1;
    wait_hs(n0 + 1, 50, "bp_release_wait");

    // Asynchronous reset while waiting for a response.
    step(3);
    check("pre_rst_pending", 32'(config_pending), 32'h00);
    reset = 1'b1;
    #1;
    check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_pending", 32'(config_pending), 32'h3F);
    check("mid_rst_link_ok", 32'(link_ok), 32'h00);
    check("mid_rst_overrun", 32'(overrun_count), 32'd0);
    step(2);
    reset = 1'b0;

    // Saturation of the overrun counter.
    k = 0;
    while (overrun_count !== 16'hFFFF && k < 70000) begin
      step(1);
      k++;
    end
    check("overrun_sat", 32'(overrun_count), 32'h0000FFFF);
    step(50);
    check("overrun_sat_hold", 32'(overrun_count), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coms_poll_scheduler.md
# coms_poll_scheduler

Sequences the motor-board serial link. Every `1/update_frequency_Hz` seconds it sweeps all motors in ascending order and issues one command per motor to the frame engine inside `coms`. The command is a pending configuration write if the host changed that motor's gains or limits, otherwise a setpoint-plus-status exchange. The block sits between the Avalon register bank, which supplies the `config_dirty` pulses, and the UART frame engine. It owns the update rate, response timeouts, per-motor link health and overrun counting.

## Interface
- `NUMBER_OF_MOTORS`, default 6: motors swept per update, 1..255.
- `CLOCK_FREQ_HZ`, default 50_000_000: `clk` frequency.
- `RESPONSE_TIMEOUT_CYCLES`, default 50_000: cycles allowed from `cmd_ready` handshake to `rsp_valid`.
- `clk` in 1: system clock; the block has one clock.
- `reset` in 1: asynchronous, active-high.
- `update_frequency_Hz` in 32: requested sweep rate; 0 means the scheduler is halted.
- `config_dirty` in `NUMBER_OF_MOTORS`: one-cycle pulse per motor, sets that motor's config-pending flag.
- `cmd_valid` out 1: command offered to the frame engine.
- `cmd_ready` in 1: frame engine accepts the command.
- `cmd_type` out 2: 2'd1 = SETPOINT_STATUS, 2'd2 = CONFIG; 0 when idle.
- `cmd_motor` out 8: target motor index.
- `rsp_valid` in 1: one-cycle pulse, response frame received.
- `rsp_ok` in 1: CRC correct; qualified by `rsp_valid`.
- `link_ok` out `NUMBER_OF_MOTORS`: result of each motor's last transaction.
- `config_pending` out `NUMBER_OF_MOTORS`: outstanding config writes.
- `sweep_done` out 1: one-cycle pulse after the last motor of a sweep.
- `overrun_count` out 16: ticks dropped because a sweep was still running; saturating.

## Operation
- **Period derivation**
  - Sub-module divider computes `period = CLOCK_FREQ_HZ / update_frequency_Hz`, truncated, clamped to at least 1.
  - The divider restarts whenever `update_frequency_Hz` differs from its latched copy.
  - While the divider is busy or the frequency is 0, no ticks are generated and the period counter is held at 0.
- **Tick**
  - The period counter counts 0..period-1.
  - A tick is generated when the counter wraps.
  - The counter restarts at 0 on divider completion.
- **FSM states: IDLE, ISSUE, WAIT_RSP, NEXT**
  - IDLE → ISSUE on tick, with motor index = 0.
  - ISSUE:
    - `cmd_valid` = 1.
    - `cmd_type` = CONFIG if `config_pending[idx]`, else SETPOINT_STATUS.
    - `cmd_type` and `cmd_motor` are held stable until `cmd_valid && cmd_ready`, then → WAIT_RSP.
    - No timeout applies while waiting for `cmd_ready`.
  - WAIT_RSP:
    - On `rsp_valid`: `link_ok[idx]` ← `rsp_ok`. If the command was CONFIG and `rsp_ok`=1, clear `config_pending[idx]`. Then → NEXT.
    - On timeout counter reaching `RESPONSE_TIMEOUT_CYCLES`-1: `link_ok[idx]` ← 0, pending flag unchanged, → NEXT.
  - NEXT:
    - If idx = `NUMBER_OF_MOTORS`-1: pulse `sweep_done`, → IDLE.
    - Else idx+1, → ISSUE.
- **Pending flags**
  - `config_dirty[i]` sets the flag.
  - If set and clear happen in the same cycle, set wins.
- **Overrun**
  - A tick in any state other than IDLE is dropped and increments `overrun_count`, saturating at 16'hFFFF.
- **Ignored inputs**
  - `rsp_valid` outside WAIT_RSP is ignored.
- **Frequency change mid-sweep**
  - The current sweep completes normally.
  - Only tick generation restarts.

## Timing
- **Reset values**
  - `cmd_valid` = 0, `cmd_type` = 0, `cmd_motor` = 0.
  - `link_ok` = 0, `config_pending` = all ones (first sweep pushes config to every motor).
  - `sweep_done` = 0, `overrun_count` = 0.
  - Divider starts immediately after reset deassertion.
- **Divider latency:** 34 cycles from a frequency change to period valid. The first tick follows after `period` further cycles.
- **Command latency:** `cmd_valid` asserts the cycle after the tick.
- **Response turnaround:** the command for the next motor is offered 2 cycles after `rsp_valid` (WAIT_RSP→NEXT→ISSUE).
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **Reset mid-operation:** outputs return to their reset values asynchronously, and the in-flight command is abandoned.

## Structure
- **Shared package `coms_pkg`**
  - `cmd_type_t` enum: NONE=0, SETPOINT_STATUS=1, CONFIG=2.
  - Scheduler state enum.
  - Default timeout constant.
- **Sub-module `period_divider`**
  - Sequential restoring divider: 32 iterations plus load and done cycles.
  - Handshake: `start`/`busy`/`done`.
  - Output quotient clamped to at least 1.

## Test plan
- **Reset and first sweep:** reset with freq=100, N=6, frame engine always ready and replying `rsp_ok`=1 after 10 cycles.
  - Six CONFIG commands, motors 0..5.
  - Afterwards `config_pending`=0, `link_ok`=6'h3F, one `sweep_done`.
  - Next tick at 500_000 cycles yields six SETPOINT_STATUS commands.
- **Config pulse:** pulse `config_dirty[3]` mid-sweep. Motor 3 receives CONFIG in the next sweep only; its flag clears on `rsp_ok`.
- **Timeout:** motor 2 never responds.
  - `link_ok[2]`=0 exactly 50_000 cycles after its handshake.
  - The sweep continues with motor 3.
  - A pending CONFIG for motor 2 is retried in the next sweep.
- **Overrun:** freq = 50_000_000 (period 1) with 100-cycle responses. `overrun_count` increments every cycle while not IDLE, and saturates when preloaded to FFFE.
- **Halt and clamp:** freq=0 → no `cmd_valid` for 10^6 cycles. freq=0xFFFFFFFF → period=1.
- **Backpressure and reset:** `cmd_ready` low for 20 cycles → `cmd_motor`/`cmd_type` stable throughout. Asserting `reset` during WAIT_RSP → `cmd_valid`=0 and `config_pending`=all ones the same cycle.
